// File: rtl/sm_insertion_count_cmp_pkg.sv
// Shared definitions for the arm insertion counter.
//   state_t  : controller states (IDLE, COUNT, DONE)
//   cw_f     : width needed to hold 0..n+1 (count, n_ref and deficit)
//   N_SM_DEF : default number of submodules per arm
package sm_sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_SM_DEF = 8;

  // One extra code above N_SM leaves room to express "n_ref > N_SM".
  function automatic int cw_f(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/sm_insertion_count_cmp_if.sv
// Request/result bundle between the sorter/modulator side and the counter.
//   master : drives start, sm_gate, n_ref; observes busy, done and results
//   slave  : the counter itself
interface sm_insertion_count_cmp_if
  import sm_sort_pkg::*;
#(
  parameter int N_SM = N_SM_DEF
);
  localparam int CW = cw_f(N_SM);

  logic            start;
  logic [N_SM-1:0] sm_gate;
  logic [CW-1:0]   n_ref;
  logic            busy;
  logic            done;
  logic [CW-1:0]   count;
  logic            ge;
  logic            eq;
  logic [CW-1:0]   deficit;

  modport master (
    output start, sm_gate, n_ref,
    input  busy, done, count, ge, eq, deficit
  );

  modport slave (
    input  start, sm_gate, n_ref,
    output busy, done, count, ge, eq, deficit
  );

endinterface

// File: rtl/sm_insertion_count_cmp_popcount_lanes.sv
// Combinational population count of one LANES-bit slice.
//   bits : LANES-bit slice
//   cnt  : number of ones in bits, $clog2(LANES+1) bits wide
module popcount_lanes #(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]           bits,
  output logic [$clog2(LANES+1)-1:0] cnt
);
  localparam int PW = $clog2(LANES + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/sm_insertion_count_cmp.sv
// Sequential submodule-insertion counter and threshold comparator for one MMC arm.
// Captures sm_gate and n_ref on an accepted start, counts LANES bits per clock,
// then publishes count, ge (count >= n_ref), eq (count == n_ref) and the
// deficit (n_ref - count, floored at 0) with a one-cycle done pulse.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   bus      : slave side of sm_insertion_count_cmp_if (start/data in,
//              busy/done/results out)
module sm_insertion_count_cmp
  import sm_sort_pkg::*;
#(
  parameter int N_SM  = N_SM_DEF,
  parameter int LANES = 2
) (
  input logic                    clk,
  input logic                    rst,
  sm_insertion_count_cmp_if.slave bus
);
  localparam int CW    = cw_f(N_SM);
  localparam int BEATS = (N_SM + LANES - 1) / LANES;
  // Padding the shift register to a whole number of beats makes the last
  // partial beat see zeros above the real submodule bits.
  localparam int SW    = BEATS * LANES;
  localparam int PW    = $clog2(LANES + 1);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t          state;
  logic [SW-1:0]   sreg;
  logic [CW-1:0]   nref_q;
  logic [CW-1:0]   acc;
  logic [BCW-1:0]  beat;
  logic [PW-1:0]   lane_cnt;

  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   count_q;
  logic            ge_q;
  logic            eq_q;
  logic [CW-1:0]   deficit_q;

  // Unsigned subtraction floored at zero.
  function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  popcount_lanes #(.LANES(LANES)) u_popcount (
    .bits (sreg[LANES-1:0]),
    .cnt  (lane_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      nref_q    <= '0;
      acc       <= '0;
      beat      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ge_q      <= 1'b0;
      eq_q      <= 1'b0;
      deficit_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= COUNT;
            busy_q <= 1'b1;
            sreg   <= SW'(bus.sm_gate);
            nref_q <= bus.n_ref;
            acc    <= '0;
            beat   <= '0;
          end
        end
        COUNT: begin
          acc  <= acc + CW'(lane_cnt);
          sreg <= sreg >> LANES;
          beat <= beat + BCW'(1);
          if (beat == BCW'(BEATS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // acc is final here; results and done are registered on leaving DONE.
          state     <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          count_q   <= acc;
          ge_q      <= (acc >= nref_q);
          eq_q      <= (acc == nref_q);
          deficit_q <= sat_sub(nref_q, acc);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;
  assign bus.ge      = ge_q;
  assign bus.eq      = eq_q;
  assign bus.deficit = deficit_q;

endmodule

// File: tb/tb_sm_insertion_count_cmp.sv
// Bench for sm_insertion_count_cmp: vector table, randomized operations
// against a popcount reference model, and hand sequences for reset,
// capture isolation, ignored starts and the N_SM=5 configurations.
module tb_sm_insertion_count_cmp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_insertion_count_cmp_if #(.N_SM(8)) bus8 ();
  sm_insertion_count_cmp_if #(.N_SM(5)) bus5a ();
  sm_insertion_count_cmp_if #(.N_SM(5)) bus5b ();

  sm_insertion_count_cmp #(.N_SM(8), .LANES(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  sm_insertion_count_cmp #(.N_SM(5), .LANES(2)) dut5a (.clk(clk), .rst(rst), .bus(bus5a));
  sm_insertion_count_cmp #(.N_SM(5), .LANES(1)) dut5b (.clk(clk), .rst(rst), .bus(bus5b));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] gate;
    logic [3:0] nref;
    int         exp_count;
    bit         exp_ge;
    bit         exp_eq;
    int         exp_def;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the N_SM=8 unit; lat = edges from the start edge to done.
  task automatic run_op(input logic [7:0] g, input logic [3:0] r, output int lat);
    bus8.sm_gate = g;
    bus8.n_ref   = r;
    bus8.start   = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus8.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int c, input bit ge,
                              input bit eq, input int d);
    check({tag, ".count"},   int'(bus8.count),   c);
    check({tag, ".ge"},      int'(bus8.ge),      int'(ge));
    check({tag, ".eq"},      int'(bus8.eq),      int'(eq));
    check({tag, ".deficit"}, int'(bus8.deficit), d);
  endtask

  initial begin
    int lat, ndone, first5a, first5b, cnt, r, d;
    logic [7:0] g;

    vecs[0] = '{8'b1011_0110, 4'd4, 5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h00,        4'd3, 0, 1'b0, 1'b0, 3};
    vecs[2] = '{8'h00,        4'd0, 0, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF,        4'd9, 8, 1'b0, 1'b0, 1};
    vecs[4] = '{8'hFF,        4'd8, 8, 1'b1, 1'b1, 0};
    vecs[5] = '{8'b0000_0001, 4'd15, 1, 1'b0, 1'b0, 14};

    bus8.start = 1'b0;  bus8.sm_gate = '0;  bus8.n_ref = '0;
    bus5a.start = 1'b0; bus5a.sm_gate = '0; bus5a.n_ref = '0;
    bus5b.start = 1'b0; bus5b.sm_gate = '0; bus5b.n_ref = '0;

    // Reset with start held high.
    rst = 1'b1;
    bus8.start = 1'b1;
    bus8.sm_gate = 8'hFF;
    tick();
    tick();
    check("rst.busy", int'(bus8.busy), 0);
    check("rst.done", int'(bus8.done), 0);
    check_result("rst", 0, 1'b0, 1'b0, 0);
    bus8.start = 1'b0;
    rst = 1'b0;
    tick();
    check("rst.no_op_busy", int'(bus8.busy), 0);

    // Vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].gate, vecs[i].nref, lat);
      check($sformatf("vec%0d.latency", i), lat, 5);
      check_result($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ge,
                   vecs[i].exp_eq, vecs[i].exp_def);
      tick();
      check($sformatf("vec%0d.done_pulse", i), int'(bus8.done), 0);
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 30; n++) begin
      g = 8'($urandom);
      r = int'($urandom_range(0, 15));
      cnt = $countones(g);
      d = (r > cnt) ? r - cnt : 0;
      run_op(g, 4'(r), lat);
      check($sformatf("rnd%0d.latency", n), lat, 5);
      check_result($sformatf("rnd%0d", n), cnt, cnt >= r, cnt == r, d);
    end

    // Outputs hold while idle regardless of input changes.
    bus8.sm_gate = 8'h0F;
    bus8.n_ref = 4'd2;
    for (int k = 0; k < 3; k++) tick();
    check("hold.count", int'(bus8.count), cnt);

    // Inputs change after capture; a start while busy is ignored.
    bus8.sm_gate = 8'hFF;
    bus8.n_ref = 4'd9;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.sm_gate = 8'h00;
    bus8.n_ref = 4'd0;
    check("iso.busy", int'(bus8.busy), 1);
    ndone = 0;
    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      bus8.start = (k == 2);
      tick();
      if (bus8.done === 1'b1) begin
        ndone++;
        if (lat == 99) lat = k;
      end
      if (k == 5) check_result("iso", 8, 1'b0, 1'b0, 1);
    end
    bus8.start = 1'b0;
    check("iso.done_count", ndone, 1);
    check("iso.latency", lat, 5);

    // Reset sampled at the third COUNT edge abandons the operation.
    bus8.sm_gate = 8'hAA;
    bus8.n_ref = 4'd2;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", int'(bus8.busy), 0);
    check("midrst.done", int'(bus8.done), 0);
    check_result("midrst", 0, 1'b0, 1'b0, 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus8.done === 1'b1) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    run_op(8'b0111_0000, 4'd3, lat);
    check("midrst.fresh_latency", lat, 5);
    check_result("midrst.fresh", 3, 1'b1, 1'b1, 0);

    // start held high: back-to-back operations one per BEATS+2 cycles.
    bus8.sm_gate = 8'h03;
    bus8.n_ref = 4'd1;
    bus8.start = 1'b1;
    tick();
    bus8.sm_gate = 8'h1F;
    bus8.n_ref = 4'd6;
    ndone = 0;
    first5a = 0;
    first5b = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus8.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first5a = k;
          check_result("b2b.first", 2, 1'b1, 1'b0, 0);
        end else begin
          first5b = k;
          check_result("b2b.second", 5, 1'b0, 1'b0, 1);
        end
      end
    end
    bus8.start = 1'b0;
    check("b2b.done_count", ndone, 2);
    check("b2b.first_latency", first5a, 5);
    check("b2b.spacing", first5b - first5a, 6);
    tick();
    tick();

    // N_SM=5 with LANES=2 (3 beats) and LANES=1 (5 beats).
    for (int t = 0; t < 2; t++) begin
      bus5a.sm_gate = (t == 0) ? 5'b11111 : 5'b10101;
      bus5b.sm_gate = bus5a.sm_gate;
      bus5a.n_ref = (t == 0) ? 3'd5 : 3'd2;
      bus5b.n_ref = bus5a.n_ref;
      bus5a.start = 1'b1;
      bus5b.start = 1'b1;
      tick();
      bus5a.start = 1'b0;
      bus5b.start = 1'b0;
      first5a = 99;
      first5b = 99;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (bus5a.done === 1'b1 && first5a == 99) begin
          first5a = k;
          check($sformatf("n5l2_%0d.count", t), int'(bus5a.count), (t == 0) ? 5 : 3);
          check($sformatf("n5l2_%0d.eq", t), int'(bus5a.eq), (t == 0) ? 1 : 0);
          check($sformatf("n5l2_%0d.ge", t), int'(bus5a.ge), 1);
        end
        if (bus5b.done === 1'b1 && first5b == 99) begin
          first5b = k;
          check($sformatf("n5l1_%0d.count", t), int'(bus5b.count), (t == 0) ? 5 : 3);
          check($sformatf("n5l1_%0d.eq", t), int'(bus5b.eq), (t == 0) ? 1 : 0);
          check($sformatf("n5l1_%0d.deficit", t), int'(bus5b.deficit), 0);
        end
      end
      check($sformatf("n5l2_%0d.latency", t), first5a, 4);
      check($sformatf("n5l1_%0d.latency", t), first5b, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
